// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: conditions the raw PS/2 lines, frames 11-bit bytes and
// turns scan-code sequences into press/release events. Define PS2_TIMEOUT_EN to add the stalled-frame watchdog.

module ps2_line_filter #(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic line_i,
  output logic level_o
);

  localparam int CW = $clog2(FILTER + 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The filtered level moves only after FILTER consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(FILTER - 1)) begin
        level_d = sync_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      meta_q  <= line_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

module ps2_receiver #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 16384
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       pressed,
  output logic       strobe,
  output logic [7:0] code,
  output logic       error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Frame word is {stop, parity, data[7:0], start} with start in bit 0.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && ((^f[9:1]) == 1'b1) && (f[10] == 1'b1);
  endfunction

  logic        ck_filt_s;
  logic        d_filt_s;
  logic        ck_prev_q;
  logic        fall_s;
  logic        timeout_s;
  logic [10:0] frame_s;
  logic [7:0]  byte_s;

  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [9:0]  shift_q;
  logic        release_q;
  logic        strobe_q;
  logic        error_q;
  logic        pressed_q;
  logic [7:0]  code_q;

  ps2_line_filter #(.FILTER(FILTER)) u_ck_filter (
    .clock   (clock),
    .reset   (reset),
    .line_i  (ps2Ck),
    .level_o (ck_filt_s)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_d_filter (
    .clock   (clock),
    .reset   (reset),
    .line_i  (ps2D),
    .level_o (d_filt_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_prev_q <= 1'b1;
    end else begin
      ck_prev_q <= ck_filt_s;
    end
  end

  assign fall_s  = ck_prev_q & ~ck_filt_s;
  assign frame_s = {d_filt_s, shift_q};
  assign byte_s  = frame_s[8:1];

`ifdef PS2_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd_q;

  // Watchdog counts idle-clock cycles inside a frame and saturates at TIMEOUT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q <= '0;
    end else if (fall_s || (state_q == S_IDLE)) begin
      wd_q <= '0;
    end else if (wd_q != WW'(TIMEOUT)) begin
      wd_q <= wd_q + WW'(1);
    end else begin
      wd_q <= wd_q;
    end
  end

  assign timeout_s = (wd_q == WW'(TIMEOUT)) && (state_q != S_IDLE) && !fall_s;
`else
  // No watchdog: a stalled frame simply resumes on later clock edges.
  assign timeout_s = (TIMEOUT < 0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 10'd0;
      release_q <= 1'b0;
      strobe_q  <= 1'b0;
      error_q   <= 1'b0;
      pressed_q <= 1'b0;
      code_q    <= 8'h00;
    end else begin
      strobe_q <= 1'b0;
      error_q  <= 1'b0;
      if (timeout_s) begin
        state_q   <= S_IDLE;
        bit_cnt_q <= 4'd0;
        release_q <= 1'b0;
        error_q   <= 1'b1;
      end else if (fall_s) begin
        shift_q <= {d_filt_s, shift_q[9:1]};
        case (state_q)
          S_IDLE: begin
            bit_cnt_q <= 4'd0;
            state_q   <= S_DATA;
          end
          S_DATA: begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_q <= S_PARITY;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_PARITY: begin
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            // F0 arms a break, E0/E1 prefixes are swallowed without touching it.
            if (!frame_ok(frame_s)) begin
              error_q   <= 1'b1;
              release_q <= 1'b0;
            end else if (byte_s == 8'hF0) begin
              release_q <= 1'b1;
            end else if ((byte_s == 8'hE0) || (byte_s == 8'hE1)) begin
              release_q <= release_q;
            end else begin
              code_q    <= byte_s;
              pressed_q <= ~release_q;
              strobe_q  <= 1'b1;
              release_q <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign pressed = pressed_q;
  assign strobe  = strobe_q;
  assign code    = code_q;
  assign error   = error_q;

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

PS/2 keyboard receiver. Decodes the serial scan-code stream from a PS/2 keyboard into one event per key action: press or release flag, strobe and 8-bit make code. Its outputs drive the pressed/strobe/code inputs of the keyboard matrix block in the machine top level. Runs entirely in the system clock domain; the PS/2 lines are asynchronous inputs.

## Interface
- `FILTER`, 8: clock cycles a synchronized PS/2 line must hold a new level before the filtered level changes.
- `TIMEOUT`, 16384: clock cycles without a filtered ps2Ck falling edge before an incomplete frame is abandoned. Used only with `PS2_TIMEOUT_EN`.
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2Ck`  in  1  PS/2 clock line, raw and asynchronous.
- `ps2D`  in  1  PS/2 data line, raw and asynchronous.
- `pressed`  out  1  1 = make, 0 = break. Valid from a strobe until the next strobe.
- `strobe`  out  1  one-cycle pulse per decoded key event.
- `code`  out  8  scan code of the event. Held until the next strobe.
- `error`  out  1  one-cycle pulse on a rejected frame.

## Operation
- Input conditioning: each line passes through a 2-FF synchronizer, then a glitch filter. The filtered level toggles only after `FILTER` consecutive synchronized samples differ from it. Filter state resets to 1 (idle-high).
- Edge detect: `fall` is a one-cycle pulse when the filtered ps2Ck goes 1→0. The filtered ps2D is sampled only on `fall`.
- Frame FSM: a 4-bit bit counter plus an 11-bit shift register.
  - IDLE: on `fall`, capture the start bit → DATA.
  - DATA: capture 8 bits, LSB first → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: capture the stop bit, validate, → IDLE.
- A frame is valid when start = 0, the 8 data bits plus the parity bit contain an odd number of 1s, and stop = 1.
- Invalid frame: pulse `error`, clear the release flag, emit no event.
- Valid byte handling:
  - 0xF0: set the release flag. No output.
  - 0xE0 or 0xE1: consumed silently. No output, flags unchanged.
  - Any other byte: `code` = byte, `pressed` = ~release, pulse `strobe`, clear the release flag.
- Repeated 0xF0 (F0 F0 xx): the release flag stays set; a single break event is emitted for xx.
- Typematic repeats of a make code each produce a separate strobe with `pressed` = 1.
- Receive only: the block never drives the PS/2 lines and sends no host-to-device commands.

## Timing
- Reset values: `pressed` 0, `strobe` 0, `code` 0x00, `error` 0. FSM in IDLE, release flag 0, filtered levels 1.
- Input latency: a clean line transition reaches the filtered level 2 + `FILTER` cycles after the raw change.
- Output latency: if the `fall` that captures the stop bit occurs in cycle N, then `strobe` or `error` is high in cycle N+1 only. `code` and `pressed` change in cycle N+1 and are stable while `strobe` is high.
- `strobe` and `error` are never high in the same cycle.
- Reset asserted mid-frame: all state returns to reset values immediately. The next `fall` after release of reset is treated as a start bit.
- A frame's ps2Ck period is at least 60 µs, so the clock rate must satisfy `FILTER` + 3 < half a PS/2 clock period in cycles.

## Configuration
- `PS2_TIMEOUT_EN` defined: a watchdog counter clears on every `fall` and runs while the FSM is not in IDLE. When it reaches `TIMEOUT`:
  - FSM → IDLE and the release flag is cleared;
  - `error` pulses for one cycle;
  - the partial frame is discarded.
- `PS2_TIMEOUT_EN` undefined: no watchdog. A partial frame resumes on subsequent edges. `TIMEOUT` is ignored.

## Test plan
- Make code: frame for 0x1C (parity bit 0) → one `strobe`; `pressed` = 1, `code` = 0x1C; `error` stays 0.
- Break code: frames 0xF0, 0x1C → exactly one `strobe`, after the second frame; `pressed` = 0, `code` = 0x1C.
- Extended code: frames 0xE0, 0xF0, 0x75 → one `strobe`; `pressed` = 0, `code` = 0x75. The E0 and F0 frames produce no strobe.
- Parity error: 0x1C sent with parity bit 1 → `error` pulse, no `strobe`. A following 0x1C frame gives `strobe` with `pressed` = 1.
- Glitch rejection: a ps2Ck low pulse of `FILTER`−2 cycles while idle → FSM stays IDLE. A following 0x1C frame decodes correctly.
- Timeout (`PS2_TIMEOUT_EN`): send 4 bits, then hold both lines high for `TIMEOUT`+10 cycles → one `error` pulse. A following 0x29 frame gives `strobe` with `code` = 0x29. Without the macro, the same stimulus gives no `error` pulse.
